// File: rtl/div_ctrl.sv
// Runtime-programmable clock divider with a req/ack divisor load. New ratios take effect only on
// a period boundary. Optional macro DIV_CTRL_AUTOSTART_EN makes the divider leave reset in RUN.
module div_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] div_in,
    input  logic             load_req,
    output logic             load_ack,
    output logic             load_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

`ifdef DIV_CTRL_AUTOSTART_EN
    localparam state_e StReset = StRun;
`else
    localparam state_e StReset = StIdle;
`endif

    localparam logic [CNT_W-1:0] DivReset = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DivMin   = CNT_W'(2);
    localparam logic [CNT_W-1:0] One      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;

    logic [CNT_W-1:0] half;
    logic             wrap;
    logic             rise;
    logic             req_take;
    logic             req_ok;

    assign half     = div_act_q >> 1;
    assign wrap     = (cnt_q == half - One);
    assign rise     = wrap && !clk_out_q;
    // A request is only looked at once per handshake: not while one is parked or being acked.
    assign req_take = load_req && !pend_q && !load_ack_q;
    assign req_ok   = (div_in >= DivMin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReset;
            cnt_q        <= '0;
            div_act_q    <= DivReset;
            div_shadow_q <= '0;
            pend_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            load_ack_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            div_shadow_q <= div_shadow_d;
            pend_q       <= pend_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            load_ack_q   <= load_ack_d;
            load_err_q   <= load_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !stop) state_d = StRun;
            StRun:   if (stop) state_d = StIdle;
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        load_ack_d   = 1'b0;
        load_err_d   = 1'b0;
        div_act_d    = div_act_q;
        div_shadow_d = div_shadow_q;
        pend_d       = pend_q;

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (req_take) begin
                    load_ack_d = 1'b1;
                    load_err_d = !req_ok;
                    if (req_ok) div_act_d = div_in;
                end
            end
            StRun: begin
                if (stop) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    if (pend_q) begin
                        div_act_d  = div_shadow_q;
                        pend_d     = 1'b0;
                        load_ack_d = 1'b1;
                    end else if (req_take) begin
                        load_ack_d = 1'b1;
                        load_err_d = !req_ok;
                        if (req_ok) div_act_d = div_in;
                    end
                end else begin
                    if (wrap) begin
                        cnt_d     = '0;
                        clk_out_d = !clk_out_q;
                        tick_d    = !clk_out_q;
                    end else begin
                        cnt_d = cnt_q + One;
                    end
                    // The rising toggle still uses the old half; the new ratio starts right after.
                    if (pend_q && rise) begin
                        div_act_d  = div_shadow_q;
                        pend_d     = 1'b0;
                        load_ack_d = 1'b1;
                    end else if (req_take) begin
                        if (req_ok) begin
                            div_shadow_d = div_in;
                            pend_d       = 1'b1;
                        end else begin
                            load_ack_d = 1'b1;
                            load_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    assign load_ack = load_ack_q;
    assign load_err = load_err_q;
    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign busy     = (state_q == StRun);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: IDLE/RUN loads, rejected loads, stop priority, odd divisor,
// stop with a pending load and asynchronous reset with a pending load.
module tb_div_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEF   = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] div_in;
    logic             load_req;
    logic             load_ack;
    logic             load_err;
    logic             clk_out;
    logic             tick;
    logic             busy;

    int checks = 0;
    int errors = 0;

    div_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .div_in  (div_in),
        .load_req(load_req),
        .load_ack(load_ack),
        .load_err(load_err),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steps until tick is seen; n = -1 if the bound expires.
    task automatic to_tick(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Called on a tick sample: cycles to the next tick and cycles clk_out was high in between.
    task automatic measure(output int period, output int high);
        period = -1;
        high   = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (clk_out === 1'b1) high++;
            if (tick === 1'b1) begin
                period = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int per;
        int hi;
        int seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        div_in   = '0;
        load_req = 1'b0;

        #12;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_load_ack", 32'(load_ack), 0);
        chk("rst_load_err", 32'(load_err), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Load 4 in IDLE: ack one cycle later.
        load_req = 1'b1;
        div_in   = 4;
        step();
        chk("idle_load_ack", 32'(load_ack), 1);
        chk("idle_load_err", 32'(load_err), 0);
        load_req = 1'b0;
        step();
        chk("idle_ack_width", 32'(load_ack), 0);

        // Start at div 4: first tick two edges after start.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e0_busy", 32'(busy), 1);
        chk("e0_clk_out", 32'(clk_out), 0);
        step();
        chk("e1_tick", 32'(tick), 0);
        step();
        chk("e2_clk_out", 32'(clk_out), 1);
        chk("e2_tick", 32'(tick), 1);
        step();
        chk("e3_clk_out", 32'(clk_out), 1);
        chk("e3_tick", 32'(tick), 0);
        step();
        chk("e4_clk_out", 32'(clk_out), 0);
        to_tick(n);
        chk("div4_tick_gap", n, 2);

        // Load 10 mid-period in RUN: ack with the next tick, then 10-cycle periods.
        step();
        load_req = 1'b1;
        div_in   = 10;
        step();
        chk("run_load_pending", 32'(load_ack), 0);
        to_tick(n);
        chk("run_load_to_tick", n, 2);
        chk("run_ack_with_tick", 32'(load_ack), 1);
        chk("run_err_with_tick", 32'(load_err), 0);
        load_req = 1'b0;
        measure(per, hi);
        chk("div10_period", per, 10);
        chk("div10_high", hi, 5);
        chk("div10_no_ack", 32'(load_ack), 0);

        // Divisor 1 is rejected; ratio stays at 10.
        load_req = 1'b1;
        div_in   = 1;
        step();
        chk("bad_load_ack", 32'(load_ack), 1);
        chk("bad_load_err", 32'(load_err), 1);
        load_req = 1'b0;
        step();
        chk("bad_ack_width", 32'(load_ack), 0);
        chk("bad_err_width", 32'(load_err), 0);
        to_tick(n);
        chk("bad_tick_gap", n, 8);
        measure(per, hi);
        chk("bad_period_kept", per, 10);

        // start and stop together: RUN -> IDLE, then stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("ss_run_busy", 32'(busy), 0);
        chk("ss_run_clk_out", 32'(clk_out), 0);
        chk("ss_run_tick", 32'(tick), 0);
        step();
        chk("ss_idle_busy", 32'(busy), 0);
        start = 1'b0;
        stop  = 1'b0;
        seen  = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (tick !== 1'b0 || clk_out !== 1'b0) seen++;
        end
        chk("ss_idle_quiet", seen, 0);

        // Odd divisor 7: period 6, 3 high.
        load_req = 1'b1;
        div_in   = 7;
        step();
        chk("div7_ack", 32'(load_ack), 1);
        load_req = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        to_tick(n);
        chk("div7_first_tick", n, 3);
        measure(per, hi);
        chk("div7_period", per, 6);
        chk("div7_high", hi, 3);

        // Stop while a load is pending applies it on the stop edge.
        load_req = 1'b1;
        div_in   = 8;
        step();
        chk("stop_pend_no_ack", 32'(load_ack), 0);
        stop = 1'b1;
        step();
        chk("stop_pend_busy", 32'(busy), 0);
        chk("stop_pend_ack", 32'(load_ack), 1);
        chk("stop_pend_clk_out", 32'(clk_out), 0);
        chk("stop_pend_tick", 32'(tick), 0);
        stop     = 1'b0;
        load_req = 1'b0;
        step();
        chk("stop_pend_ack_width", 32'(load_ack), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        to_tick(n);
        chk("div8_first_tick", n, 4);
        measure(per, hi);
        chk("div8_period", per, 8);

        // Asynchronous reset with a load pending: discarded, back to DEFAULT_DIV.
        load_req = 1'b1;
        div_in   = 20;
        step();
        chk("rst_pend_no_ack", 32'(load_ack), 0);
        chk("rst_pend_clk_high", 32'(clk_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clk_out", 32'(clk_out), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_ack", 32'(load_ack), 0);
        load_req = 1'b0;
        step();
        step();
        chk("in_rst_ack", 32'(load_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ack", 32'(load_ack), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        to_tick(n);
        chk("def_first_tick", n, DEF / 2);
        measure(per, hi);
        chk("def_period", per, DEF);
        chk("def_high", hi, DEF / 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
